// File: rtl/demux2_stream.sv
// -----------------------------------------------------------------------------
// demux2_stream
//
// Registered 1-to-2 stream demultiplexer. One valid/ready input stream carries
// a per-beat select bit. Each beat is steered into the one-entry holding
// register of output channel 0 or 1. Each channel has its own backpressure,
// so a stalled consumer never blocks beats bound for the other channel. A
// saturating counter per channel records how many beats were delivered, for
// debug.
//
// Parameters:
//   WIDTH  payload width of the input and both outputs
//   CNT_W  width of each per-channel delivered-beat counter
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    input beat present
//   in_ready    demux accepts the offered beat this cycle (combinational)
//   in_sel      destination channel of the beat (qualified by in_valid)
//   in_data     input payload
//   out0_valid  channel 0 holds a beat
//   out0_ready  channel 0 consumer accepts
//   out0_data   channel 0 payload
//   out1_valid  channel 1 holds a beat
//   out1_ready  channel 1 consumer accepts
//   out1_data   channel 1 payload
//   cnt0        beats delivered on channel 0, saturating
//   cnt1        beats delivered on channel 1, saturating
// -----------------------------------------------------------------------------
module demux2_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-channel state, index = channel number. The valid bit is the channel
  // state: 0 = EMPTY, 1 = FULL.
  logic [1:0]            r_valid;
  logic [1:0][WIDTH-1:0] r_data;
  logic [1:0][CNT_W-1:0] r_cnt;

  logic [1:0] w_out_ready;
  logic [1:0] w_chan_ready;
  logic [1:0] w_drain;
  logic [1:0] w_load;
  logic       w_xfer;

  assign w_out_ready = {out1_ready, out0_ready};

  // A channel can take a new beat when it is empty, or when its held beat
  // leaves on this same edge. This allows one beat per cycle per channel.
  assign w_chan_ready = ~r_valid | w_out_ready;
  assign w_drain      = r_valid & w_out_ready;

  // Only the selected channel decides acceptance, so backpressure from one
  // consumer never stalls traffic to the other.
  assign in_ready = w_chan_ready[in_sel];
  assign w_xfer   = in_valid & in_ready;
  assign w_load   = {w_xfer & in_sel, w_xfer & ~in_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset along with the valid bits so no X
      // ever reaches the outputs, even though the data is only meaningful while
      // valid is high.
      r_valid <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every channel sees the
      // pre-edge values of r_valid when load and drain happen together.
      for (int k = 0; k < 2; k++) begin
        if (w_load[k]) begin
          // Covers EMPTY->FULL and the drain-and-refill FULL->FULL case.
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data;
        end else if (w_drain[k]) begin
          // Data is left in place after a drain; only valid drops.
          r_valid[k] <= 1'b0;
        end

        if (w_drain[k] && (r_cnt[k] != CNT_MAX)) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign out0_valid = r_valid[0];
  assign out0_data  = r_data[0];
  assign out1_valid = r_valid[1];
  assign out1_data  = r_data[1];
  assign cnt0       = r_cnt[0];
  assign cnt1       = r_cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// -----------------------------------------------------------------------------
// tb_demux2_stream
//
// Self-checking bench for demux2_stream. A table of directed vectors (inputs
// plus hand-computed in_ready and post-edge outputs) covers acceptance,
// backpressure, drain-and-refill and cross-channel independence. Hand-written
// sequences cover asynchronous reset mid-operation and counter saturation on
// a CNT_W=4 instance.
// -----------------------------------------------------------------------------
module tb_demux2_stream;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int SW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Main instance signals
  logic          in_valid, in_ready, in_sel;
  logic [W-1:0]  in_data;
  logic          out0_valid, out0_ready, out1_valid, out1_ready;
  logic [W-1:0]  out0_data, out1_data;
  logic [CW-1:0] cnt0, cnt1;

  // Small-counter instance signals
  logic          s_in_valid, s_in_ready, s_in_sel;
  logic [W-1:0]  s_in_data;
  logic          s_out0_valid, s_out0_ready, s_out1_valid, s_out1_ready;
  logic [W-1:0]  s_out0_data, s_out1_data;
  logic [SW-1:0] s_cnt0, s_cnt1;

  demux2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  demux2_stream #(.WIDTH(W), .CNT_W(SW)) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_sel     (s_in_sel),
    .in_data    (s_in_data),
    .out0_valid (s_out0_valid),
    .out0_ready (s_out0_ready),
    .out0_data  (s_out0_data),
    .out1_valid (s_out1_valid),
    .out1_ready (s_out1_ready),
    .out1_data  (s_out1_data),
    .cnt0       (s_cnt0),
    .cnt1       (s_cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic          iv;
    logic          sel;
    logic [W-1:0]  d;
    logic          r0;
    logic          r1;
    logic          e_ready;   // in_ready before the edge
    logic          e_v0;      // outputs after the edge
    logic [W-1:0]  e_d0;
    logic          e_v1;
    logic [W-1:0]  e_d1;
    logic [CW-1:0] e_c0;
    logic [CW-1:0] e_c1;
  } vec_t;

  function automatic vec_t mk(
    input logic iv, input logic sel, input logic [W-1:0] d,
    input logic r0, input logic r1, input logic e_ready,
    input logic e_v0, input logic [W-1:0] e_d0,
    input logic e_v1, input logic [W-1:0] e_d1,
    input int e_c0, input int e_c1);
    vec_t v;
    v.iv = iv; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1;
    v.e_ready = e_ready;
    v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_v1 = e_v1; v.e_d1 = e_d1;
    v.e_c0 = CW'(e_c0); v.e_c1 = CW'(e_c1);
    return v;
  endfunction

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check_outputs(input string tag, input logic v0,
                               input logic [W-1:0] d0, input logic v1,
                               input logic [W-1:0] d1, input logic [CW-1:0] c0,
                               input logic [CW-1:0] c1);
    check({tag, ".out0_valid"}, W'(out0_valid), W'(v0));
    check({tag, ".out0_data"},  out0_data,      d0);
    check({tag, ".out1_valid"}, W'(out1_valid), W'(v1));
    check({tag, ".out1_data"},  out1_data,      d1);
    check({tag, ".cnt0"},       W'(cnt0),       W'(c0));
    check({tag, ".cnt1"},       W'(cnt1),       W'(c1));
  endtask

  initial begin
    // iv sel data          r0 r1 rdy  v0 d0             v1 d1            c0 c1
    // Single beat to ch0, then its drain.
    vecs[0]  = mk(1, 0, 32'h11111111, 1, 0, 1,  1, 32'h11111111, 0, 32'h0,        0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 0, 1,  0, 32'h11111111, 0, 32'h0,        1, 0);
    // ch0 backpressure: A held, B refused, then drain+refill.
    vecs[2]  = mk(1, 0, 32'hA,        0, 0, 1,  1, 32'hA,        0, 32'h0,        1, 0);
    vecs[3]  = mk(1, 0, 32'hB,        0, 0, 0,  1, 32'hA,        0, 32'h0,        1, 0);
    vecs[4]  = mk(1, 0, 32'hB,        1, 0, 1,  1, 32'hB,        0, 32'h0,        2, 0);
    // ch0 stalled FULL, ch1 streams 1,2,3 at full rate.
    vecs[5]  = mk(1, 1, 32'h1,        0, 1, 1,  1, 32'hB,        1, 32'h1,        2, 0);
    vecs[6]  = mk(1, 1, 32'h2,        0, 1, 1,  1, 32'hB,        1, 32'h2,        2, 1);
    vecs[7]  = mk(1, 1, 32'h3,        0, 1, 1,  1, 32'hB,        1, 32'h3,        2, 2);
    vecs[8]  = mk(0, 1, 32'h0,        0, 1, 1,  1, 32'hB,        0, 32'h3,        2, 3);
    // Fill ch1, then ch1 beat offered while ch1 stalled and ch0 drains.
    vecs[9]  = mk(1, 1, 32'hC,        0, 0, 1,  1, 32'hB,        1, 32'hC,        2, 3);
    vecs[10] = mk(1, 1, 32'hD,        1, 0, 0,  0, 32'hB,        1, 32'hC,        3, 3);
    // Refill ch0; then ch0 drain+refill while ch1 drains.
    vecs[11] = mk(1, 0, 32'hE,        0, 0, 1,  1, 32'hE,        1, 32'hC,        3, 3);
    vecs[12] = mk(1, 0, 32'hF,        1, 1, 1,  1, 32'hF,        0, 32'hC,        4, 4);
    // in_valid=0 with garbage payload: no state change.
    vecs[13] = mk(0, 1, 32'hDEAD,     0, 0, 1,  1, 32'hF,        0, 32'hC,        4, 4);
    // Fill ch1 so both channels are FULL before the reset sequence.
    vecs[14] = mk(1, 1, 32'h12345678, 0, 0, 1,  1, 32'hF,        1, 32'h12345678, 4, 4);

    in_valid = 0; in_sel = 0; in_data = '0; out0_ready = 0; out1_ready = 0;
    s_in_valid = 0; s_in_sel = 0; s_in_data = '0; s_out0_ready = 0; s_out1_ready = 0;

    // Reset state.
    #12;
    check("rst.in_ready", W'(in_ready), W'(1'b1));
    check_outputs("rst", 0, '0, 0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid   = vecs[i].iv;
      in_sel     = vecs[i].sel;
      in_data    = vecs[i].d;
      out0_ready = vecs[i].r0;
      out1_ready = vecs[i].r1;
      #1;
      check($sformatf("v%0d.in_ready", i), W'(in_ready), W'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].e_v0, vecs[i].e_d0,
                    vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_c0, vecs[i].e_c1);
    end

    // Asynchronous reset mid-cycle with both channels FULL.
    in_valid = 0; out0_ready = 0; out1_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.in_ready", W'(in_ready), W'(1'b1));
    check_outputs("async_rst", 0, '0, 0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // First beat after release behaves like the very first transfer.
    @(negedge clk);
    in_valid = 1; in_sel = 0; in_data = 32'h11111111; out0_ready = 1;
    #1;
    check("post_rst.in_ready", W'(in_ready), W'(1'b1));
    @(posedge clk);
    #1;
    check_outputs("post_rst.beat", 1, 32'h11111111, 0, '0, '0, '0);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    #1;
    check_outputs("post_rst.drain", 0, 32'h11111111, 0, '0, 1, '0);

    // Saturation on the CNT_W=4 instance: 20 beats through ch0 at full rate.
    // Beat n is accepted at edge n and drained at edge n+1.
    @(negedge clk);
    s_out0_ready = 1;
    for (int k = 1; k <= 21; k++) begin
      s_in_valid = (k <= 20);
      s_in_data  = W'(k);
      @(posedge clk);
      #1;
      check($sformatf("sat.e%0d.cnt0", k), W'(s_cnt0),
            W'((k - 1 > 15) ? 15 : k - 1));
      @(negedge clk);
    end
    s_in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("sat.hold.cnt0", W'(s_cnt0), W'(15));
    check("sat.hold.cnt1", W'(s_cnt1), W'(0));
    check("sat.hold.out0_valid", W'(s_out0_valid), W'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
